// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types for the keypad matrix scanner.
//   - key_state_t : debounce FSM state {IDLE, DEB_PRESS, PRESSED, DEB_REL}
//   - frame_res_t : classification of one full matrix frame {NONE, SINGLE, MULTI}
//   - KEY_W       : key-code width for the default 4x4 matrix
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } key_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_res_t;

   localparam int KEY_W = $clog2(4 * 4);

endpackage

// File: rtl/keypad_frame_eval.sv
// keypad_frame_eval
//   Combinational classifier for one complete matrix snapshot.
//   Ports:
//     iSNAP   in  N_KEY   snapshot, bit col*N_ROW+row, active-low (0 = key down)
//     oRESULT out 2       NONE (no key), SINGLE (exactly one key), MULTI (two or more)
//     oCODE   out CODE_W  index of the lowest asserted key; meaningful only for SINGLE
module keypad_frame_eval
   import keypad_pkg::*;
#(
   parameter int N_KEY  = 16,
   parameter int CODE_W = KEY_W
) (
   input  logic [N_KEY-1:0]  iSNAP,
   output frame_res_t        oRESULT,
   output logic [CODE_W-1:0] oCODE
);

   localparam int CNT_W = $clog2(N_KEY + 1);

   logic [CNT_W-1:0] keyCount;

   // Popcount and priority encode in one pass; walking downward leaves the
   // lowest asserted index in oCODE.
   always_comb begin
      keyCount = '0;
      oCODE    = '0;
      for (int i = N_KEY - 1; i >= 0; i--) begin
         if (!iSNAP[i]) begin
            keyCount = keyCount + 1'b1;
            oCODE    = CODE_W'(i);
         end
      end
      if (keyCount == '0)
         oRESULT = NONE;
      else if (keyCount == CNT_W'(1))
         oRESULT = SINGLE;
      else
         oRESULT = MULTI;
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans an N_COL x N_ROW key matrix by driving one column low at a time,
//   samples the active-low rows through a 2-FF synchronizer, classifies each
//   full frame and runs a debounce / ghost-rejection FSM once per frame.
//   Ports:
//     iCLK         in  1       clock
//     nRST         in  1       synchronous reset, active-high
//     iROW         in  N_ROW   row sense, active-low, asynchronous
//     oCOL         out N_COL   column drive, one-cold (0 = driven)
//     oKEY_CODE    out CODE_W  last accepted key = col*N_ROW + row
//     oKEY_VALID   out 1       1-cycle pulse: press accepted (or auto-repeat)
//     oKEY_HELD    out 1       level: accepted key still down
//     oKEY_RELEASE out 1       1-cycle pulse: release accepted
//     oSTATE       out 2       current debounce FSM state (debug)
//   Build option: define KEYPAD_AUTOREPEAT_EN to re-pulse oKEY_VALID while a
//   key is held (first after REPEAT_DELAY frames, then every REPEAT_RATE).
//   Pulses appear on the cycle after the frame-evaluation strobe, since all
//   FSM outputs are registered.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int N_COL           = 4,
   parameter int N_ROW           = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_RATE     = 10
) (
   input  logic                             iCLK,
   input  logic                             nRST,
   input  logic [N_ROW-1:0]                 iROW,
   output logic [N_COL-1:0]                 oCOL,
   output logic [$clog2(N_COL*N_ROW)-1:0]   oKEY_CODE,
   output logic                             oKEY_VALID,
   output logic                             oKEY_HELD,
   output logic                             oKEY_RELEASE,
   output key_state_t                       oSTATE
);

   localparam int N_KEY  = N_COL * N_ROW;
   localparam int CODE_W = $clog2(N_KEY);
   localparam int COL_W  = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam int DW_W   = $clog2(SCAN_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_matrix_scanner: SCAN_DIV must be >= 4");
   end
   if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
      $error("keypad_matrix_scanner: DEBOUNCE_FRAMES must be >= 1");
   end
   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
      $error("keypad_matrix_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   // ---------------------------------------------------------------- scan
   logic              scanActive;   // low only on the first cycle out of reset
   logic [COL_W-1:0]  col, colNext;
   logic [DW_W-1:0]   dwell, dwellNext;
   logic              lastDwell, lastCol;
   logic [N_ROW-1:0]  rowMeta, rowSync;
   logic [N_KEY-1:0]  snap;
   logic              evalStb;

   assign lastDwell = (dwell == DW_W'(SCAN_DIV - 1));
   assign lastCol   = (col == COL_W'(N_COL - 1));

   always_comb begin
      dwellNext = dwell;
      colNext   = col;
      if (scanActive) begin
         if (lastDwell) begin
            dwellNext = '0;
            colNext   = lastCol ? '0 : col + 1'b1;
         end else begin
            dwellNext = dwell + 1'b1;
         end
      end
   end

   // The first post-reset edge only starts the scan, so column 0 gets a full
   // SCAN_DIV dwell like every other column. oCOL is registered from colNext
   // so it always matches the column being counted.
   always_ff @(posedge iCLK) begin
      if (nRST) begin
         scanActive <= 1'b0;
         col        <= '0;
         dwell      <= '0;
         oCOL       <= '1;
         rowMeta    <= '1;
         rowSync    <= '1;
         snap       <= '1;
         evalStb    <= 1'b0;
      end else begin
         scanActive <= 1'b1;
         col        <= colNext;
         dwell      <= dwellNext;
         oCOL       <= ~(N_COL'(1) << colNext);
         rowMeta    <= iROW;
         rowSync    <= rowMeta;
         evalStb    <= scanActive && lastDwell && lastCol;
         // Latch at the end of the dwell: the synchronizer has long settled on
         // this column's rows by then.
         if (scanActive && lastDwell)
            snap[col*N_ROW +: N_ROW] <= rowSync;
      end
   end

   // ---------------------------------------------------------- frame eval
   frame_res_t        frameRes;
   logic [CODE_W-1:0] frameCode;

   keypad_frame_eval #(
      .N_KEY  (N_KEY),
      .CODE_W (CODE_W)
   ) u_frame_eval (
      .iSNAP   (snap),
      .oRESULT (frameRes),
      .oCODE   (frameCode)
   );

   // ----------------------------------------------------------------- FSM
   key_state_t        state;
   logic [CODE_W-1:0] cand;
   logic [DB_W-1:0]   debCnt;
   logic              debDone;
   logic              sameKey;

   assign debDone = ((debCnt + 1'b1) >= DB_W'(DEBOUNCE_FRAMES));
   assign sameKey = (frameRes == SINGLE) && (frameCode == cand);
   assign oSTATE  = state;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rptCnt;
   logic             rptArmed;   // first repeat already issued -> use REPEAT_RATE
   logic [RPT_W-1:0] rptTarget;

   assign rptTarget = rptArmed ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
`endif

   always_ff @(posedge iCLK) begin
      if (nRST) begin
         state        <= IDLE;
         cand         <= '0;
         debCnt       <= '0;
         oKEY_CODE    <= '0;
         oKEY_VALID   <= 1'b0;
         oKEY_HELD    <= 1'b0;
         oKEY_RELEASE <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rptCnt       <= '0;
         rptArmed     <= 1'b0;
`endif
      end else begin
         oKEY_VALID   <= 1'b0;
         oKEY_RELEASE <= 1'b0;
         if (evalStb) begin
            case (state)
               IDLE: begin
                  if (frameRes == SINGLE) begin
                     cand   <= frameCode;
                     debCnt <= DB_W'(1);
                     if (DEBOUNCE_FRAMES == 1) begin
                        state      <= PRESSED;
                        oKEY_CODE  <= frameCode;
                        oKEY_VALID <= 1'b1;
                        oKEY_HELD  <= 1'b1;
                     end else begin
                        state <= DEB_PRESS;
                     end
`ifdef KEYPAD_AUTOREPEAT_EN
                     rptCnt   <= '0;
                     rptArmed <= 1'b0;
`endif
                  end
               end

               DEB_PRESS: begin
                  if (sameKey) begin
                     debCnt <= debCnt + 1'b1;
                     if (debDone) begin
                        state      <= PRESSED;
                        oKEY_CODE  <= cand;
                        oKEY_VALID <= 1'b1;
                        oKEY_HELD  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end

               PRESSED: begin
                  // MULTI is treated as ghosting and a different single key
                  // must wait for a release, so only NONE leaves this state.
                  if (frameRes == NONE) begin
                     debCnt <= DB_W'(1);
                     if (DEBOUNCE_FRAMES == 1) begin
                        state        <= IDLE;
                        oKEY_HELD    <= 1'b0;
                        oKEY_RELEASE <= 1'b1;
                     end else begin
                        state <= DEB_REL;
                     end
`ifdef KEYPAD_AUTOREPEAT_EN
                     rptCnt   <= '0;
                     rptArmed <= 1'b0;
`endif
                  end
`ifdef KEYPAD_AUTOREPEAT_EN
                  // Ghost or other-key frames fall through and pause the count.
                  else if (sameKey) begin
                     if ((rptCnt + 1'b1) == rptTarget) begin
                        oKEY_VALID <= 1'b1;
                        rptCnt     <= '0;
                        rptArmed   <= 1'b1;
                     end else begin
                        rptCnt <= rptCnt + 1'b1;
                     end
                  end
`endif
               end

               DEB_REL: begin
                  if (frameRes == NONE) begin
                     debCnt <= debCnt + 1'b1;
                     if (debDone) begin
                        state        <= IDLE;
                        oKEY_HELD    <= 1'b0;
                        oKEY_RELEASE <= 1'b1;
                     end
                  end else begin
                     state <= PRESSED;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
//   Directed bench for keypad_matrix_scanner with a 4x4 matrix, SCAN_DIV=4 and
//   DEBOUNCE_FRAMES=2 (one frame = 16 cycles). A behavioural matrix model
//   turns the set of pressed keys into iROW from the driven column. Pulses are
//   time-stamped with the cycle count since reset release and compared with
//   hand-computed stamps: frame j is evaluated and its pulse is visible at
//   cycle 16*j + 2.
//   Define KEYPAD_AUTOREPEAT_EN for the auto-repeat expectations.
module tb_keypad_matrix_scanner;
   import keypad_pkg::*;

   localparam int FRAME = 16;
   localparam int WAIT_LIMIT = 2000;

   // ------------------------------------------------------ clock / reset
   logic       iCLK = 1'b0;
   logic       nRST = 1'b1;
   logic [3:0] iROW;
   logic [3:0] oCOL;
   logic [3:0] oKEY_CODE;
   logic       oKEY_VALID;
   logic       oKEY_HELD;
   logic       oKEY_RELEASE;
   key_state_t oSTATE;

   always #5 iCLK = ~iCLK;

   keypad_matrix_scanner #(
      .N_COL           (4),
      .N_ROW           (4),
      .SCAN_DIV        (4),
      .DEBOUNCE_FRAMES (2),
      .REPEAT_DELAY    (3),
      .REPEAT_RATE     (2)
   ) dut (
      .iCLK         (iCLK),
      .nRST         (nRST),
      .iROW         (iROW),
      .oCOL         (oCOL),
      .oKEY_CODE    (oKEY_CODE),
      .oKEY_VALID   (oKEY_VALID),
      .oKEY_HELD    (oKEY_HELD),
      .oKEY_RELEASE (oKEY_RELEASE),
      .oSTATE       (oSTATE)
   );

   // Matrix model: a pressed key pulls its row low while its column is driven.
   logic [15:0] keys = '0;

   always_comb begin
      iROW = '1;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4 + r] && !oCOL[c])
               iROW[r] = 1'b0;
   end

   int cyc = 0;
   always @(posedge iCLK) begin
      if (nRST) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // ----------------------------------------------------------- scoreboard
   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] valid_q[$];
   logic [15:0] rel_q[$];

   always @(negedge iCLK) begin
      if (oKEY_VALID)   valid_q.push_back(16'(cyc));
      if (oKEY_RELEASE) rel_q.push_back(16'(cyc));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compares the recorded VALID (use_rel=0) or RELEASE (use_rel=1) stamps
   // against exp_q.
   task automatic check_pulses(input string tag, input bit use_rel);
      logic [15:0] got_q[$];
      got_q = use_rel ? rel_q : valid_q;
      chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_stamp%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   // ------------------------------------------------------------- drivers
   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc < target && guard < WAIT_LIMIT) begin
         @(negedge iCLK);
         guard++;
      end
      if (guard >= WAIT_LIMIT) chk("wait_timeout", 32'(cyc), 32'(target));
   endtask

   // Keys for frame j are applied just after the last column of frame j-1
   // has been latched.
   task automatic set_frame(input int j, input logic [15:0] k);
      wait_cyc(FRAME*(j-1) + 1);
      keys = k;
   endtask

   task automatic do_reset();
      keys = '0;
      nRST = 1'b1;
      repeat (3) @(negedge iCLK);
      nRST = 1'b0;
      valid_q.delete();
      rel_q.delete();
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main
   initial begin
      logic [3:0] expCol;

      // 1. reset state and column sequence
      keys = '0;
      nRST = 1'b1;
      repeat (3) @(negedge iCLK);
      chk("rst_col",     32'(oCOL), 32'h0000_000F);
      chk("rst_code",    32'(oKEY_CODE), 0);
      chk("rst_valid",   32'(oKEY_VALID), 0);
      chk("rst_held",    32'(oKEY_HELD), 0);
      chk("rst_release", 32'(oKEY_RELEASE), 0);
      chk("rst_state",   32'(oSTATE), 32'(IDLE));
      nRST = 1'b0;
      valid_q.delete();
      rel_q.delete();
      for (int i = 0; i < 20; i++) begin
         wait_cyc(i + 1);
         expCol = ~(4'b0001 << ((i / 4) % 4));
         chk($sformatf("scan_col_c%0d", i + 1), 32'(oCOL), 32'(expCol));
      end

      // 2+3. key 6 (col 1, row 2) for 3 frames, then released
      do_reset();
      set_frame(1, 16'h0040);
      set_frame(2, 16'h0040);
      set_frame(3, 16'h0040);
      wait_cyc(40);
      chk("press_held",  32'(oKEY_HELD), 1);
      chk("press_code",  32'(oKEY_CODE), 6);
      chk("press_state", 32'(oSTATE), 32'(PRESSED));
      set_frame(4, 16'h0000);
      set_frame(5, 16'h0000);
      wait_cyc(FRAME*5 + 4);
      exp_q = '{16'd34};
      check_pulses("press_valid", 1'b0);
      exp_q = '{16'd82};
      check_pulses("press_release", 1'b1);
      chk("release_held",  32'(oKEY_HELD), 0);
      chk("release_code",  32'(oKEY_CODE), 6);
      chk("release_state", 32'(oSTATE), 32'(IDLE));

      // 4. bounce: present, absent, present, present
      do_reset();
      set_frame(1, 16'h0040);
      set_frame(2, 16'h0000);
      set_frame(3, 16'h0040);
      set_frame(4, 16'h0040);
      wait_cyc(FRAME*4 + 4);
      exp_q = '{16'd66};
      check_pulses("bounce_valid", 1'b0);
      exp_q = {};
      check_pulses("bounce_release", 1'b1);
      chk("bounce_held", 32'(oKEY_HELD), 1);

      // 5. ghosting: 6+9 from idle, then 6 alone, then 9 added while held
      do_reset();
      set_frame(1, 16'h0240);
      set_frame(2, 16'h0240);
      set_frame(3, 16'h0240);
      wait_cyc(FRAME*3 + 4);
      chk("ghost_idle_held",  32'(oKEY_HELD), 0);
      chk("ghost_idle_state", 32'(oSTATE), 32'(IDLE));
      set_frame(4, 16'h0040);
      set_frame(5, 16'h0040);
      set_frame(6, 16'h0240);
      set_frame(7, 16'h0240);
      wait_cyc(FRAME*7 + 4);
      exp_q = '{16'd82};
      check_pulses("ghost_valid", 1'b0);
      exp_q = {};
      check_pulses("ghost_release", 1'b1);
      chk("ghost_held", 32'(oKEY_HELD), 1);
      chk("ghost_code", 32'(oKEY_CODE), 6);

      // 6. key 0 held for 10 frames
      do_reset();
      for (int j = 1; j <= 10; j++) set_frame(j, 16'h0001);
      wait_cyc(FRAME*10 + 4);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_q = '{16'd34, 16'd82, 16'd114, 16'd146};
`else
      exp_q = '{16'd34};
`endif
      check_pulses("hold_valid", 1'b0);
      chk("hold_held", 32'(oKEY_HELD), 1);
      chk("hold_code", 32'(oKEY_CODE), 0);

      // 6b. reset mid-frame while key 15 is held, then full debounce again
      do_reset();
      set_frame(1, 16'h8000);
      wait_cyc(40);
      chk("mid_pre_held", 32'(oKEY_HELD), 1);
      chk("mid_pre_code", 32'(oKEY_CODE), 15);
      nRST = 1'b1;
      repeat (2) @(negedge iCLK);
      chk("mid_rst_held",    32'(oKEY_HELD), 0);
      chk("mid_rst_valid",   32'(oKEY_VALID), 0);
      chk("mid_rst_release", 32'(oKEY_RELEASE), 0);
      chk("mid_rst_col",     32'(oCOL), 32'h0000_000F);
      chk("mid_rst_code",    32'(oKEY_CODE), 0);
      nRST = 1'b0;
      wait_cyc(FRAME*2 + 4);
      exp_q = '{16'd34, 16'd34};
      check_pulses("mid_valid", 1'b0);
      exp_q = {};
      check_pulses("mid_release", 1'b1);
      chk("mid_post_held", 32'(oKEY_HELD), 1);
      chk("mid_post_code", 32'(oKEY_CODE), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
